muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 6 +
 rtl/muldiv_sign_fix.sv | 11 +
 rtl/muldiv_unit.sv | 122 ++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared FSM state encoding and operation codes for muldiv_unit
package muldiv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: two's-complement negate-or-pass, used both for operand magnitudes and result sign correction
// Ports: i_x value, i_neg negate when 1, o_y result
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_neg ? -i_x : i_x;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply (shift-add) / divide (restoring), one bit per cycle on operand magnitudes
// Ports: clk, reset (sync, active-high); start/op/is_signed/a/b request inputs captured in IDLE;
//        busy, done (one-cycle pulse), div_zero, hi (product high / remainder), lo (product low / quotient)
// Config: define MULDIV_SIGNED_EN to honour is_signed; otherwise all operands are unsigned
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc, r_q, r_b, r_hi, r_lo;
    logic             r_op, r_nlo, r_nhi, r_busy, r_done, r_dz;
    logic             w_sa, w_sb, w_ge;
    logic [WIDTH-1:0] w_amag, w_bmag, w_acc_n, w_q_n, w_hi_res, w_lo_res;
    logic [WIDTH:0]   w_sum, w_sh;
`ifdef MULDIV_SIGNED_EN
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;
    assign w_sa = is_signed & a[WIDTH-1];
    assign w_sb = is_signed & b[WIDTH-1];
    // product sign is the xor of operand signs; remainder follows the dividend
    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_p (.i_x({r_acc, r_q}), .i_neg(r_nlo), .o_y(w_prod));
    muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_q (.i_x(r_q),          .i_neg(r_nlo), .o_y(w_quo));
    muldiv_sign_fix #(.WIDTH(WIDTH))   u_fix_r (.i_x(r_acc),        .i_neg(r_nhi), .o_y(w_rem));
    assign w_hi_res = (r_op == OP_DIV) ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo_res = (r_op == OP_DIV) ? w_quo : w_prod[WIDTH-1:0];
`else
    logic w_unused;
    assign w_sa     = 1'b0;
    assign w_sb     = 1'b0;
    assign w_unused = ^{is_signed, r_nlo, r_nhi};
    assign w_hi_res = r_acc;
    assign w_lo_res = r_q;
`endif
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.i_x(a), .i_neg(w_sa), .o_y(w_amag));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.i_x(b), .i_neg(w_sb), .o_y(w_bmag));
    // multiply: {acc,q} shifts right, adding the multiplicand when the next multiplier bit is set
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    // divide: {acc,q} shifts left, subtracting the divisor when it fits; wrap in the subtract is harmless
    // because the kept difference is always below the divisor
    assign w_sh    = {r_acc, r_q[WIDTH-1]};
    assign w_ge    = w_sh >= {1'b0, r_b};
    assign w_acc_n = (r_op == OP_MUL) ? w_sum[WIDTH:1] : (w_ge ? w_sh[WIDTH-1:0] - r_b : w_sh[WIDTH-1:0]);
    assign w_q_n   = (r_op == OP_MUL) ? {w_sum[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_ge};
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= 1'b0;
            r_nlo   <= 1'b0;
            r_nhi   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_op   <= op;
                    r_nlo  <= w_sa ^ w_sb;
                    r_nhi  <= w_sa;
                    r_acc  <= '0;
                    r_q    <= w_amag;
                    r_b    <= w_bmag;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                    if (op == OP_DIV && b == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_dz    <= 1'b1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= FIX;
                end
                FIX: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_dz    <= 1'b0;
                    r_hi    <= w_hi_res;
                    r_lo    <= w_lo_res;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         reset, start, op, is_signed;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    int           vectors = 0;
    int           errors = 0;
    logic [W-1:0] exp_hi, exp_lo;
    logic         exp_dz;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    // reference: plain 64-bit arithmetic; SV division truncates toward zero and % follows the dividend
    function automatic logic [63:0] ref_result(input logic f_op, input logic f_sgn, input logic [31:0] f_a, input logic [31:0] f_b);
        longint sa, sb;
        logic [63:0] r;
        sa = f_sgn ? longint'($signed(f_a)) : longint'({32'b0, f_a});
        sb = f_sgn ? longint'($signed(f_b)) : longint'({32'b0, f_b});
        if (!f_op) r = f_sgn ? 64'(sa * sb) : ({32'b0, f_a} * {32'b0, f_b});
        else       r = {32'(sa % sb), 32'(sa / sb)};
        return r;
    endfunction

    task automatic predict(input logic t_op, input logic t_sgn, input logic [31:0] t_a, input logic [31:0] t_b, output int e_lat);
        logic [63:0] r;
        if (t_op && t_b == 32'd0) begin
            exp_dz = 1'b1;
            e_lat = 1;
        end else begin
            r = ref_result(t_op, t_sgn && SEN, t_a, t_b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            exp_dz = 1'b0;
            e_lat = W + 2;
        end
    endtask

    // drives one request and observes a fixed window; inputs are scrambled after capture
    task automatic do_op(input logic t_op, input logic t_sgn, input logic [31:0] t_a, input logic [31:0] t_b,
                         input int restart_at, input int reset_at,
                         output int lat, output int nd, output int nb,
                         output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                         output logic pb, output logic [31:0] ph, output logic [31:0] pl, output logic pd);
        op = t_op; is_signed = t_sgn; a = t_a; b = t_b; start = 1'b1;
        lat = -1; nd = 0; nb = 0; rh = '0; rl = '0; rdz = 1'b0; pb = 1'b1; ph = '1; pl = '1; pd = 1'b1;
        for (int n = 1; n <= W + 6; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reset = 1'b0;
            if (n == 1) begin
                a = $urandom; b = $urandom; op = ~t_op; is_signed = ~t_sgn;
            end
            if (done) begin
                nd++;
                if (lat < 0) begin
                    lat = n; rh = hi; rl = lo; rdz = div_zero;
                end
            end
            if (busy) nb++;
            if (reset_at > 0 && n == reset_at + 1) begin
                pb = busy; ph = hi; pl = lo; pd = done;
            end
            if (n == restart_at) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            if (n == reset_at) reset = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd5; b = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        vectors++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset div_zero: got %b want 0", div_zero); end
        vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL reset hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL reset lo: got %h want 0", lo); end
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_prio busy: got %b want 0", busy); end
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    endtask

    task automatic test_mul_max;
        int lat, nd, nb, el;
        logic [31:0] rh, rl, ph, pl;
        logic rdz, pb, pd;
        predict(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, el);
        do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat, nd, nb, rh, rl, rdz, pb, ph, pl, pd);
        vectors++; if (lat !== 34) begin errors++; $display("FAIL mul_max latency: got %0d want 34", lat); end
        vectors++; if (nd !== 1) begin errors++; $display("FAIL mul_max done_count: got %0d want 1", nd); end
        vectors++; if (nb !== 34) begin errors++; $display("FAIL mul_max busy_cycles: got %0d want 34", nb); end
        vectors++; if (rh !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_max hi: got %h want fffffffe", rh); end
        vectors++; if (rl !== 32'h00000001) begin errors++; $display("FAIL mul_max lo: got %h want 00000001", rl); end
        vectors++; if (rdz !== 1'b0) begin errors++; $display("FAIL mul_max div_zero: got %b want 0", rdz); end
    endtask

    task automatic test_signed;
        int lat, nd, nb, el;
        logic [31:0] rh, rl, ph, pl;
        logic rdz, pb, pd;
        logic [31:0] ta [3] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] tb [3] = '{32'd7, 32'd2, 32'hFFFFFFFF};
        logic        to [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            predict(to[i], 1'b1, ta[i], tb[i], el);
            do_op(to[i], 1'b1, ta[i], tb[i], 0, 0, lat, nd, nb, rh, rl, rdz, pb, ph, pl, pd);
            vectors++; if (lat !== el) begin errors++; $display("FAIL signed[%0d] latency: got %0d want %0d", i, lat, el); end
            vectors++; if (rh !== exp_hi) begin errors++; $display("FAIL signed[%0d] hi: got %h want %h", i, rh, exp_hi); end
            vectors++; if (rl !== exp_lo) begin errors++; $display("FAIL signed[%0d] lo: got %h want %h", i, rl, exp_lo); end
            vectors++; if (rdz !== 1'b0) begin errors++; $display("FAIL signed[%0d] div_zero: got %b want 0", i, rdz); end
        end
    endtask

    task automatic test_div_zero;
        int lat, nd, nb, el;
        logic [31:0] rh, rl, ph, pl, prev_hi, prev_lo;
        logic rdz, pb, pd;
        prev_hi = exp_hi; prev_lo = exp_lo;
        predict(1'b1, 1'b0, 32'd5, 32'd0, el);
        do_op(1'b1, 1'b0, 32'd5, 32'd0, 0, 0, lat, nd, nb, rh, rl, rdz, pb, ph, pl, pd);
        vectors++; if (lat !== 1) begin errors++; $display("FAIL div0 latency: got %0d want 1", lat); end
        vectors++; if (nd !== 1) begin errors++; $display("FAIL div0 done_count: got %0d want 1", nd); end
        vectors++; if (nb !== 1) begin errors++; $display("FAIL div0 busy_cycles: got %0d want 1", nb); end
        vectors++; if (rdz !== 1'b1) begin errors++; $display("FAIL div0 div_zero: got %b want 1", rdz); end
        vectors++; if (rh !== prev_hi) begin errors++; $display("FAIL div0 hi: got %h want %h", rh, prev_hi); end
        vectors++; if (rl !== prev_lo) begin errors++; $display("FAIL div0 lo: got %h want %h", rl, prev_lo); end
        vectors++; if (div_zero !== 1'b1) begin errors++; $display("FAIL div0 held: got %b want 1", div_zero); end
        predict(1'b0, 1'b0, 32'd9, 32'd11, el);
        do_op(1'b0, 1'b0, 32'd9, 32'd11, 0, 0, lat, nd, nb, rh, rl, rdz, pb, ph, pl, pd);
        vectors++; if (rdz !== 1'b0) begin errors++; $display("FAIL div0 clear: got %b want 0", rdz); end
        vectors++; if (rl !== exp_lo) begin errors++; $display("FAIL div0 next lo: got %h want %h", rl, exp_lo); end
    endtask

    task automatic test_restart;
        int lat, nd, nb, el;
        logic [31:0] rh, rl, ph, pl, ra, rb;
        logic rdz, pb, pd;
        ra = $urandom; rb = $urandom;
        predict(1'b0, 1'b0, ra, rb, el);
        do_op(1'b0, 1'b0, ra, rb, 5, 0, lat, nd, nb, rh, rl, rdz, pb, ph, pl, pd);
        vectors++; if (lat !== 34) begin errors++; $display("FAIL restart latency: got %0d want 34", lat); end
        vectors++; if (nd !== 1) begin errors++; $display("FAIL restart done_count: got %0d want 1", nd); end
        vectors++; if (rh !== exp_hi) begin errors++; $display("FAIL restart hi: got %h want %h", rh, exp_hi); end
        vectors++; if (rl !== exp_lo) begin errors++; $display("FAIL restart lo: got %h want %h", rl, exp_lo); end
    endtask

    task automatic test_reset_abort;
        int lat, nd, nb;
        logic [31:0] rh, rl, ph, pl;
        logic rdz, pb, pd;
        do_op(1'b1, 1'b0, $urandom, 32'd3, 0, 10, lat, nd, nb, rh, rl, rdz, pb, ph, pl, pd);
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        vectors++; if (pb !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", pb); end
        vectors++; if (ph !== 32'd0) begin errors++; $display("FAIL abort hi: got %h want 0", ph); end
        vectors++; if (pl !== 32'd0) begin errors++; $display("FAIL abort lo: got %h want 0", pl); end
        vectors++; if (pd !== 1'b0) begin errors++; $display("FAIL abort done: got %b want 0", pd); end
        vectors++; if (nd !== 0) begin errors++; $display("FAIL abort done_count: got %0d want 0", nd); end
    endtask

    task automatic test_random;
        int lat, nd, nb, el;
        logic [31:0] rh, rl, ph, pl, ra, rb;
        logic rdz, pb, pd, ro, rs;
        for (int i = 0; i < 30; i++) begin
            ro = 1'($urandom); rs = 1'($urandom); ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (i % 7 == 3) ra = 32'h80000000;
            predict(ro, rs, ra, rb, el);
            do_op(ro, rs, ra, rb, 0, 0, lat, nd, nb, rh, rl, rdz, pb, ph, pl, pd);
            vectors++; if (lat !== el) begin errors++; $display("FAIL rand[%0d] latency: got %0d want %0d", i, lat, el); end
            vectors++; if (nd !== 1) begin errors++; $display("FAIL rand[%0d] done_count: got %0d want 1", i, nd); end
            vectors++; if (rh !== exp_hi) begin errors++; $display("FAIL rand[%0d] hi: got %h want %h (op=%b s=%b a=%h b=%h)", i, rh, exp_hi, ro, rs, ra, rb); end
            vectors++; if (rl !== exp_lo) begin errors++; $display("FAIL rand[%0d] lo: got %h want %h (op=%b s=%b a=%h b=%h)", i, rl, exp_lo, ro, rs, ra, rb); end
            vectors++; if (rdz !== exp_dz) begin errors++; $display("FAIL rand[%0d] div_zero: got %b want %b", i, rdz, exp_dz); end
        end
    endtask

    initial begin
        test_reset;
        test_mul_max;
        test_signed;
        test_div_zero;
        test_restart;
        test_reset_abort;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
